ext_sram_ctrl: RTL

EXT_SRAM_CTRL -- requirements
Module: ext_sram_ctrl

---
 rtl/ext_sram_pkg.sv | 41 ++++
 rtl/sram_pipe_delay.sv | 37 +++
 rtl/ext_sram_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ext_sram_pkg.sv
// Shared timing constants, FSM encoding and small helpers for the
// NoBL/ZBT pipelined SRAM controller.
package ext_sram_pkg;

  // Clocks from the accept edge until write data is launched onto the bus.
  localparam int WR_DATA_DLY   = 2;
  // Clocks from the accept edge until read data is registered from the bus.
  localparam int RD_LATENCY    = 3;
  // Dead cycles inserted on a read-to-write bus turnaround.
  localparam int TURN_CYCLES   = 1;

  // The tagged delay lines must hold a command for the longest path.
  localparam int PIPE_DEPTH    = RD_LATENCY;

  // Pipeline taps: the entry sitting in tap N is launched/captured on the
  // next edge, so each tap is one less than its edge offset from accept.
  localparam int WR_TAP        = WR_DATA_DLY - 1;
  localparam int RD_OE_TAP     = RD_LATENCY - 2;
  localparam int RD_CAP_TAP    = RD_LATENCY - 1;

  // A write may not follow a read accepted this many edges back or fewer,
  // otherwise its data drive would butt against the read data slot.
  localparam int RD_HAZARD_WIN = RD_LATENCY - TURN_CYCLES;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  // A pipeline entry is a read when it is valid and not flagged as a write.
  function automatic logic is_rd(input logic valid, input logic write);
    return valid & ~write;
  endfunction

  // A pipeline entry is a write when it is valid and flagged as a write.
  function automatic logic is_wr(input logic valid, input logic write);
    return valid & write;
  endfunction

endpackage

// File: rtl/sram_pipe_delay.sv
// Fixed-depth tagged delay line. Every stage is exposed so the parent can
// tap whichever offset it needs; only the valid/write tags are reset.
module sram_pipe_delay
  import ext_sram_pkg::*;
#(
  parameter int W     = 36,
  parameter int DEPTH = PIPE_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in_write,
  input  logic [W-1:0]              in_data,
  output logic [DEPTH-1:0]          q_valid,
  output logic [DEPTH-1:0]          q_write,
  output logic [DEPTH-1:0][W-1:0]   q_data
);

  // Shift the tags one stage per clock; reset empties the line at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
    if (reset) begin
      q_valid <= '0;
      q_write <= '0;
    end else begin
      q_valid <= {q_valid[DEPTH-2:0], in_valid};
      q_write <= {q_write[DEPTH-2:0], in_write};
    end
  end

  // Shift the payload alongside the tags.
  always_ff @(posedge clk) begin
    // NOTE: payload is left unreset; the valid tag alone decides whether it is ever used.
    q_data <= {q_data[DEPTH-2:0], in_data};
  end

endmodule

// File: rtl/ext_sram_ctrl.sv
// Controller for a NoBL/ZBT pipelined synchronous SRAM. Commands arrive
// on a valid/ready handshake; every pin is driven straight from a flop so
// it can be packed into the IOB. Writes launch data two clocks after
// accept, reads return three clocks after accept, and a read followed by
// a write gets one stall cycle to turn the bus around.
module ext_sram_ctrl
  import ext_sram_pkg::*;
#(
  parameter int AWIDTH = 21,
  parameter int DWIDTH = 36
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,

  output logic              rd_valid,
  output logic [DWIDTH-1:0] rd_data,

  output logic [AWIDTH-1:0] RAM_A,
  output logic              RAM_WEn,
  output logic              RAM_CE1n,
  output logic              RAM_CENn,
  output logic              RAM_OEn,
  output logic              RAM_LDn,
  output logic [DWIDTH-1:0] RAM_D_po,
  output logic              RAM_D_poe,
  input  logic [DWIDTH-1:0] RAM_D_pi
);

  state_t state;
  state_t state_d;

  logic   ready_en;
  logic   xfer;
  logic   recent_read;
  logic   turn_hit;

  logic [PIPE_DEPTH-1:0]             wr_q_valid;
  logic [PIPE_DEPTH-1:0]             wr_q_write;
  logic [PIPE_DEPTH-1:0][DWIDTH-1:0] wr_q_data;

  logic [PIPE_DEPTH-1:0]             rd_q_valid;
  logic [PIPE_DEPTH-1:0]             rd_q_write;
  logic [PIPE_DEPTH-1:0][AWIDTH-1:0] rd_q_data;

  logic                              wr_launch;
  logic                              rd_in_slot;
  logic                              rd_capture;

  // Only one tap of the write line and the tags of the read line are
  // consumed; the rest of those vectors is folded here on purpose.
  logic                              unused_taps;

  assign xfer        = cmd_valid & cmd_ready;

  // A read accepted within the hazard window blocks an incoming write.
  assign recent_read = |(rd_q_valid[RD_HAZARD_WIN-1:0] & ~rd_q_write[RD_HAZARD_WIN-1:0]);

  // The turnaround stall is raised the cycle the write shows up; the TURN
  // cycle that follows lets it through, so the stall is never repeated.
  assign turn_hit    = (state != ST_TURN) & cmd_valid & cmd_write & recent_read;

  assign wr_launch   = is_wr(wr_q_valid[WR_TAP], wr_q_write[WR_TAP]);
  assign rd_in_slot  = is_rd(rd_q_valid[RD_OE_TAP], rd_q_write[RD_OE_TAP]);
  assign rd_capture  = is_rd(rd_q_valid[RD_CAP_TAP], rd_q_write[RD_CAP_TAP]);

  assign unused_taps = ^{wr_q_valid, wr_q_write, wr_q_data, rd_q_data};

  // Write path: carries the write data until its bus slot.
  sram_pipe_delay #(
    .W     (DWIDTH),
    .DEPTH (PIPE_DEPTH)
  ) u_wr_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (xfer),
    .in_write (cmd_write),
    .in_data  (cmd_wdata),
    .q_valid  (wr_q_valid),
    .q_write  (wr_q_write),
    .q_data   (wr_q_data)
  );

  // Read path: carries the address as a tag until the data is captured.
  sram_pipe_delay #(
    .W     (AWIDTH),
    .DEPTH (PIPE_DEPTH)
  ) u_rd_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (xfer),
    .in_write (cmd_write),
    .in_data  (cmd_addr),
    .q_valid  (rd_q_valid),
    .q_write  (rd_q_write),
    .q_data   (rd_q_data)
  );

  // Hold off cmd_ready until the first edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next state: track activity and enter TURN on a read-to-write hazard.
  always_comb begin
    // NOTE: default assignment first so no branch leaves state_d unassigned and a latch is inferred.
    state_d = state;
    unique case (state)
      ST_IDLE, ST_RUN: begin
        if (turn_hit && !clear) begin
          state_d = ST_TURN;
        end else if (xfer) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TURN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: accept commands unless held in reset, flushing, or stalling.
  always_comb begin
    cmd_ready = 1'b0;
    if (ready_en && !clear && !turn_hit) begin
      cmd_ready = 1'b1;
    end
  end

  // SRAM pins: address/control on accept, data drive and OE from pipe taps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RAM_A     <= '0;
      RAM_WEn   <= 1'b1;
      RAM_CE1n  <= 1'b1;
      RAM_CENn  <= 1'b0;
      RAM_OEn   <= 1'b1;
      RAM_LDn   <= 1'b0;
      RAM_D_po  <= '0;
      RAM_D_poe <= 1'b1;
    end else begin
      RAM_CENn  <= 1'b0;
      RAM_LDn   <= 1'b0;
      RAM_CE1n  <= ~xfer;
      RAM_WEn   <= ~(xfer & cmd_write);
      if (xfer) begin
        RAM_A <= cmd_addr;
      end
      RAM_OEn   <= ~rd_in_slot;
      RAM_D_poe <= ~wr_launch;
      if (wr_launch) begin
        RAM_D_po <= wr_q_data[WR_TAP];
      end
    end
  end

  // Read return: register the bus in the read's capture slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_capture;
      if (rd_capture) begin
        rd_data <= RAM_D_pi;
      end
    end
  end

endmodule
